spike_detector_mc: RTL and testbench
====================================

SPIKE_DETECTOR_MC -- requirements
Module: spike_detector_mc

Interface
REQ-001 SHALL have parameter NCH, default 4: number of independent sensor channels.
REQ-002 SHALL have parameter DW, default 11: signed sample width per channel.
REQ-003 SHALL have parameter ASH, default 3: baseline IIR shift (alpha = 2^-ASH).
REQ-004 SHALL have parameter REFR, default 8: refractory length, in valid samples.
REQ-005 SHALL have parameter THR_DEFAULT, default 200: threshold loaded at reset, DW+1 bits unsigned.
REQ-006 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-008 SHALL have port enable  input  1: threshold serial-load strobe.
REQ-009 SHALL have port din  input  1: threshold serial data, MSB first.
REQ-010 SHALL have port x_valid  input  1: all channels of x valid this cycle.
REQ-011 SHALL have port x  input  NCH*DW: packed signed samples, channel 0 in LSBs.
REQ-012 SHALL have port spike_valid  output  1: spike vector valid.
REQ-013 SHALL have port spike  output  NCH: per-channel spike flag.
REQ-014 SHALL have port busy  output  1: threshold load in progress.

Function
REQ-015 SHALL run per channel a baseline accumulator acc (DW+ASH bits signed), updated only on x_valid: acc <= acc + x - (acc >>> ASH).
REQ-016 SHALL form z = x - (acc >>> ASH), saturated to DW bits signed (max/min clamp, no wrap).
REQ-017 SHALL form emphasis q = z[n] - z[n-1], DW+1 bits signed, full precision, no saturation.
REQ-018 SHALL compare |q| (DW+1 bits unsigned; |most-negative| = 2^DW) strictly greater than active threshold thr.
REQ-019 SHALL be three-stage pipelined: x_valid at cycle t gives spike_valid at t+3; spike_valid is x_valid delayed 3 cycles.
REQ-020 SHALL assert spike[i] only with spike_valid, when compare true and channel refractory counter is zero.
REQ-021 SHALL load refractory counter with REFR on a spike; decrement once per valid sample while nonzero; no spike while nonzero.
REQ-022 SHALL drive spike to all-zero whenever spike_valid is low.
REQ-023 SHALL implement load FSM states ARMED, LOAD: ARMED->LOAD on enable=1 (that cycle's din is bit 1); LOAD shifts din each enable=1 cycle.
REQ-024 SHALL commit shadow register to thr and return to ARMED when DW+1 bits are received; thr takes effect for compares in the following cycle.
REQ-025 SHALL, on enable=0 in LOAD before bit count complete, abort: discard shadow, keep old thr, return to ARMED.
REQ-026 SHALL keep detecting with the old thr throughout LOAD; busy high exactly while in LOAD.
REQ-027 SHALL treat channels independently; simultaneous spikes on several channels all report in the same cycle.

Reset
REQ-028 SHALL, when rst=0 at a clock edge: clear acc, z, q, refractory counters, pipeline valids; set thr=THR_DEFAULT, FSM=ARMED, busy=0, spike=0, spike_valid=0.
REQ-029 SHALL, on reset mid-load or mid-pipeline, discard in-flight samples and partial threshold without producing spike_valid.

Configuration
REQ-030 SHALL, with SPIKE_CNT_EN defined, add output spike_cnt NCH*16: per-channel 16-bit counters, +1 per spike, saturating at 65535, cleared by reset.
REQ-031 SHALL, without SPIKE_CNT_EN, omit the spike_cnt port and counter logic entirely; other behaviour identical.

Structure
REQ-032 SHALL place parameter defaults, the FSM state typedef (ARMED, LOAD) and the counter width constant in shared package spike_pkg.
REQ-033 SHALL implement one channel (filter, emphasis, compare, refractory, optional counter) as sub-module spike_chan, instantiated NCH times via generate; threshold FSM stays in the top.

Verification
REQ-034 SHALL test: reset, all x=0 for 50 valid cycles -> spike_valid follows x_valid by 3, spike never set.
REQ-035 SHALL test: channel 2 step 0 -> 500 with thr=200 -> one spike on channel 2 only, 3 cycles after step; no repeat within 8 valid samples.
REQ-036 SHALL test: load 12-bit thr=600 (MSB first, 12 enable cycles) then repeat step 0->500 -> no spike; busy high for exactly 12 cycles.
REQ-037 SHALL test: enable drops after 5 bits -> thr stays 200, busy falls, next 0->500 step spikes.
REQ-038 SHALL test: x alternating -1024/+1023 every sample on all channels -> z saturates, no wrap, spikes on all 4 channels simultaneously, spaced by refractory.
REQ-039 SHALL test: with SPIKE_CNT_EN, 70000 forced spikes on channel 0 -> spike_cnt[0] holds 65535; rst=0 mid-stream -> counter 0, no spike_valid for 3 cycles.

Source files
------------

// File: rtl/spike_pkg.sv
// Shared defaults, threshold-loader state type and counter width for the
// multi-channel spike detector.
package spike_pkg;

    localparam int NCH_DEF         = 4;
    localparam int DW_DEF          = 11;
    localparam int ASH_DEF         = 3;
    localparam int REFR_DEF        = 8;
    localparam int THR_DEFAULT_DEF = 200;
    localparam int CNT_W           = 16;

    typedef enum logic {
        ARMED = 1'b0,
        LOAD  = 1'b1
    } thr_state_e;

    // Refractory counter width; at least one bit even when REFR is zero.
    function automatic int rc_width(input int refr);
        return (refr > 0) ? $clog2(refr + 1) : 1;
    endfunction

endpackage

// File: rtl/spike_chan.sv
// One detector channel: IIR baseline removal with saturation, first-difference
// emphasis, magnitude threshold and refractory gate. SPIKE_CNT_EN adds a counter.
module spike_chan
    import spike_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ASH  = ASH_DEF,
    parameter int REFR = REFR_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s0_valid_i,
    input  logic          s1_valid_i,
    input  logic          s2_valid_i,
    input  logic [DW-1:0] x_i,
    input  logic [DW:0]   thr_i,
    output logic          spike_o
`ifdef SPIKE_CNT_EN
    ,
    output logic [CNT_W-1:0] spike_cnt_o
`endif
);

    localparam int AW = DW + ASH;
    localparam int RW = rc_width(REFR);
    localparam logic [DW-1:0] Z_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] Z_MIN = {1'b1, {(DW-1){1'b0}}};

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [DW-1:0] base_s;
    logic [DW:0]          diff_s;
    logic [DW-1:0]        z_d;
    logic [DW-1:0]        z_q;
    logic [DW-1:0]        zp_q;
    logic [DW:0]          q_d;
    logic [DW:0]          q_q;
    logic [DW:0]          mag_s;
    logic [RW-1:0]        rc_q;
    logic                 spike_q;
    logic                 fire_s;

    // Baseline update, clamped residual, emphasis difference and |q| compare.
    always_comb begin
        base_s = DW'(acc_q >>> ASH);
        acc_d  = acc_q + {{ASH{x_i[DW-1]}}, x_i} - {{ASH{base_s[DW-1]}}, base_s};
        diff_s = {x_i[DW-1], x_i} - {base_s[DW-1], base_s};
        if (diff_s[DW] != diff_s[DW-1]) begin
            z_d = diff_s[DW] ? Z_MIN : Z_MAX;
        end else begin
            z_d = diff_s[DW-1:0];
        end
        q_d = {z_q[DW-1], z_q} - {zp_q[DW-1], zp_q};
        if (q_q[DW]) begin
            mag_s = ~q_q + (DW+1)'(1);
        end else begin
            mag_s = q_q;
        end
        fire_s = (rc_q == '0) && (mag_s > thr_i);
    end

    // Three pipeline stages: residual, emphasis, refractory-gated decision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q   <= '0;
            z_q     <= '0;
            zp_q    <= '0;
            q_q     <= '0;
            rc_q    <= '0;
            spike_q <= 1'b0;
        end else begin
            if (s0_valid_i) begin
                acc_q <= acc_d;
                z_q   <= z_d;
            end
            if (s1_valid_i) begin
                q_q  <= q_d;
                zp_q <= z_q;
            end
            if (s2_valid_i) begin
                spike_q <= fire_s;
                if (rc_q != '0) begin
                    rc_q <= rc_q - RW'(1);
                end else if (fire_s) begin
                    rc_q <= RW'(REFR);
                end
            end else begin
                spike_q <= 1'b0;
            end
        end
    end

    assign spike_o = spike_q;

`ifdef SPIKE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating spike counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (s2_valid_i && fire_s && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign spike_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/spike_detector_mc.sv
// Multi-channel spike detector top: serial threshold loader, shared valid
// pipeline and NCH channel instances. SPIKE_CNT_EN adds per-channel counters.
module spike_detector_mc
    import spike_pkg::*;
#(
    parameter int NCH         = NCH_DEF,
    parameter int DW          = DW_DEF,
    parameter int ASH         = ASH_DEF,
    parameter int REFR        = REFR_DEF,
    parameter int THR_DEFAULT = THR_DEFAULT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               din,
    input  logic               x_valid,
    input  logic [NCH*DW-1:0]  x,
    output logic               spike_valid,
    output logic [NCH-1:0]     spike,
`ifdef SPIKE_CNT_EN
    output logic [NCH*CNT_W-1:0] spike_cnt,
`endif
    output logic               busy
);

    localparam int TW = DW + 1;
    localparam int BW = $clog2(TW + 1);

    thr_state_e     state_q;
    logic [TW-1:0]  thr_q;
    logic [TW-1:0]  shadow_q;
    logic [BW-1:0]  bit_cnt_q;
    logic           busy_q;
    logic           v1_q;
    logic           v2_q;
    logic           sv_q;

    // Threshold loader; the commit happens one cycle after the last bit lands.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ARMED;
            thr_q     <= TW'(THR_DEFAULT);
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ARMED: begin
                    if (enable) begin
                        shadow_q  <= {{(TW-1){1'b0}}, din};
                        bit_cnt_q <= BW'(1);
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bit_cnt_q == BW'(TW)) begin
                        thr_q   <= shadow_q;
                        state_q <= ARMED;
                        busy_q  <= 1'b0;
                    end else if (enable) begin
                        shadow_q  <= {shadow_q[TW-2:0], din};
                        bit_cnt_q <= bit_cnt_q + BW'(1);
                    end else begin
                        shadow_q <= '0;
                        state_q  <= ARMED;
                        busy_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARMED;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Sample-valid pipeline shared by all channels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            sv_q <= 1'b0;
        end else begin
            v1_q <= x_valid;
            v2_q <= v1_q;
            sv_q <= v2_q;
        end
    end

    assign spike_valid = sv_q;
    assign busy        = busy_q;

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_chan
            spike_chan #(
                .DW   (DW),
                .ASH  (ASH),
                .REFR (REFR)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .s0_valid_i (x_valid),
                .s1_valid_i (v1_q),
                .s2_valid_i (v2_q),
                .x_i        (x[g*DW +: DW]),
                .thr_i      (thr_q),
                .spike_o    (spike[g])
`ifdef SPIKE_CNT_EN
                ,
                .spike_cnt_o (spike_cnt[g*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_spike_detector_mc.sv
// Directed self-checking bench for spike_detector_mc; the SPIKE_CNT_EN build
// adds a counter-saturation run on a second instance with no refractory.
module tb_spike_detector_mc;

    localparam int NCH = 4;
    localparam int DW  = 11;
    localparam int XW  = NCH * DW;
    localparam logic [DW-1:0] NEG  = 11'h400;
    localparam logic [DW-1:0] POS  = 11'h3FF;
    localparam logic [DW-1:0] STEP = 11'd500;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           enable = 1'b0;
    logic           din = 1'b0;
    logic           x_valid = 1'b0;
    logic [XW-1:0]  x = '0;
    logic           spike_valid;
    logic [NCH-1:0] spike;
    logic           busy;

    int             n_assert = 0;
    int             n_fail = 0;
    int             busy_cnt;
    logic [2:0]     hv = '0;
    logic [NCH-1:0] hs0 = '0;
    logic [NCH-1:0] hs1 = '0;
    logic [NCH-1:0] hs2 = '0;
    logic [11:0]    v600 = 12'd600;

    always #5 clk = ~clk;

`ifdef SPIKE_CNT_EN
    logic [NCH*16-1:0] cnt_main;
    logic [NCH*16-1:0] cnt_sat;
    logic              sx_valid = 1'b0;
    logic [XW-1:0]     sx = '0;
    logic              s_sv;
    logic [NCH-1:0]    s_spike;
    logic              s_busy;
    logic              tgl = 1'b0;
`endif

    spike_detector_mc dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .din         (din),
        .x_valid     (x_valid),
        .x           (x),
        .spike_valid (spike_valid),
        .spike       (spike),
`ifdef SPIKE_CNT_EN
        .spike_cnt   (cnt_main),
`endif
        .busy        (busy)
    );

`ifdef SPIKE_CNT_EN
    spike_detector_mc #(.REFR(0)) u_sat (
        .clk         (clk),
        .rst         (rst),
        .enable      (1'b0),
        .din         (1'b0),
        .x_valid     (sx_valid),
        .x           (sx),
        .spike_valid (s_sv),
        .spike       (s_spike),
        .spike_cnt   (cnt_sat),
        .busy        (s_busy)
    );
`endif

    function automatic logic [XW-1:0] chx(input int ch, input logic [DW-1:0] v);
        logic [XW-1:0] r;
        r = '0;
        r[ch*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [XW-1:0] allx(input logic [DW-1:0] v);
        return {NCH{v}};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then compare outputs against the delayed expectations.
    task automatic tick(input logic xv, input logic [XW-1:0] xvec, input logic en,
                        input logic d, input logic [NCH-1:0] esp);
        x_valid = xv;
        x       = xvec;
        enable  = en;
        din     = d;
        @(posedge clk);
        #1;
        if (rst == 1'b0) begin
            hv  = '0;
            hs0 = '0;
            hs1 = '0;
            hs2 = '0;
        end else begin
            hv  = {hv[1:0], xv};
            hs2 = hs1;
            hs1 = hs0;
            hs0 = xv ? esp : '0;
        end
        chk("spike_valid", {31'd0, spike_valid}, {31'd0, hv[2]});
        chk("spike", {28'd0, spike}, {28'd0, hs2});
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        rst = 1'b1;
        chk("busy_reset", {31'd0, busy}, 32'd0);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic load(input logic [11:0] v, input int nbits);
        busy_cnt = 0;
        for (int k = 0; k < nbits; k++) begin
            tick(1'b0, '0, 1'b1, v[11-k], '0);
            if (busy === 1'b1) busy_cnt++;
        end
        tick(1'b0, '0, 1'b0, 1'b0, '0);
        chk("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

`ifdef SPIKE_CNT_EN
    task automatic sat_tick(input logic xv);
        x_valid  = 1'b0;
        sx_valid = xv;
        sx       = chx(0, tgl ? POS : NEG);
        if (xv) tgl = ~tgl;
        @(posedge clk);
        #1;
    endtask
`endif

    initial begin
        // Quiet input: valid pattern with gaps, no spikes ever.
        do_reset();
        for (int i = 0; i < 60; i++) tick((i % 7) != 3, '0, 1'b0, 1'b0, '0);
        flush();

        // Single step on channel 2 with default threshold 200.
        do_reset();
        tick(1'b1, chx(2, STEP), 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 20; i++) tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        flush();

        // Threshold 600 loaded; same step must not fire.
        do_reset();
        load(12'd600, 12);
        chk("busy_cycles_full", busy_cnt, 32'd12);
        for (int i = 0; i < 12; i++) tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        flush();

        // Aborted load after 5 bits keeps 200.
        do_reset();
        load(12'd600, 5);
        chk("busy_cycles_abort", busy_cnt, 32'd5);
        tick(1'b1, chx(2, STEP), 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 10; i++) tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        flush();

        // Detection continues with the old threshold while loading.
        do_reset();
        for (int k = 0; k < 12; k++)
            tick(1'b1, (k >= 1) ? chx(2, STEP) : '0, 1'b1, v600[11-k],
                 (k == 1) ? 4'b0100 : 4'b0000);
        chk("busy_in_load", {31'd0, busy}, 32'd1);
        tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        chk("busy_commit", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        flush();

        // Full-scale alternation: all channels fire together every 9 samples.
        do_reset();
        for (int i = 0; i < 30; i++)
            tick(1'b1, allx((i % 2 == 0) ? NEG : POS), 1'b0, 1'b0,
                 (i % 9 == 0) ? 4'hF : 4'h0);
        flush();

        // Threshold 1500 separates saturation from wrap on the second sample.
        do_reset();
        load(12'd1500, 12);
        for (int i = 0; i < 12; i++)
            tick(1'b1, allx((i % 2 == 0) ? NEG : POS), 1'b0, 1'b0,
                 (i == 1 || i == 10) ? 4'hF : 4'h0);
        flush();

        // Reset mid-load and mid-pipeline discards everything in flight.
        do_reset();
        tick(1'b0, '0, 1'b1, 1'b1, '0);
        tick(1'b1, chx(2, STEP), 1'b1, 1'b1, 4'b0100);
        rst = 1'b0;
        tick(1'b1, chx(2, STEP), 1'b1, 1'b1, '0);
        chk("busy_mid_reset", {31'd0, busy}, 32'd0);
        rst = 1'b1;
        flush();
        tick(1'b1, chx(2, STEP), 1'b0, 1'b0, 4'b0100);
        for (int i = 0; i < 4; i++) tick(1'b1, chx(2, STEP), 1'b0, 1'b0, '0);
        flush();

`ifdef SPIKE_CNT_EN
        do_reset();
        tgl = 1'b0;
        for (int i = 0; i < 100; i++) sat_tick(1'b1);
        for (int i = 0; i < 3; i++) sat_tick(1'b0);
        chk("cnt_100", {16'd0, cnt_sat[15:0]}, 32'd100);
        for (int i = 0; i < 70000; i++) sat_tick(1'b1);
        for (int i = 0; i < 3; i++) sat_tick(1'b0);
        chk("cnt_sat", {16'd0, cnt_sat[15:0]}, 32'd65535);
        chk("cnt_ch1", {16'd0, cnt_sat[31:16]}, 32'd0);
        for (int i = 0; i < 4; i++) sat_tick(1'b1);
        rst = 1'b0;
        sat_tick(1'b1);
        chk("cnt_reset", {16'd0, cnt_sat[15:0]}, 32'd0);
        chk("sv_reset0", {31'd0, s_sv}, 32'd0);
        rst = 1'b1;
        sat_tick(1'b1);
        chk("sv_reset1", {31'd0, s_sv}, 32'd0);
        sat_tick(1'b1);
        chk("sv_reset2", {31'd0, s_sv}, 32'd0);
        sat_tick(1'b1);
        chk("sv_resume", {31'd0, s_sv}, 32'd1);
        sat_tick(1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
